trace_replay_tx: RTL and testbench
==================================

// Module: trace_replay_tx
// PURPOSE
//  Transmit end of the lockstep-check path. Captures a LENGTH-bit trace sample stream
//  from the core side, buffers it, and sends it to the checker over valid/ready with a
//  sequence tag. Flags dropped samples and can corrupt one sample on demand, so the
//  checker's mismatch detection can be exercised in silicon.
// PARAMETERS
//  LENGTH  32  trace sample width in bits
//  DEPTH   8   buffer entries; power of 2, >= 2
//  SEQ_W   8   sequence tag width; wraps modulo 2**SEQ_W
// PORTS
//  clk         in   1                 clock, all state on rising edge
//  rst_l       in   1                 reset, asynchronous assert, active-low
//  in_valid    in   1                 trace sample present this cycle (no backpressure)
//  in_data     in   LENGTH            trace sample
//  flush       in   1                 sync clear of buffer, tag, sticky flags
//  inject_err  in   1                 pulse: arm corruption of next sent sample
//  out_valid   out  1                 head sample available
//  out_ready   in   1                 checker accepts head sample
//  out_data    out  LENGTH            head sample (bit 0 inverted if injection armed)
//  out_seq     out  SEQ_W             tag of head sample
//  overflow    out  1                 sticky: at least one sample dropped
//  level       out  $clog2(DEPTH)+1   entries currently held
// BEHAVIOUR
//  Reset (rst_l=0, async): out_valid=0, out_data=0, out_seq=0, overflow=0, level=0;
//   buffer empty, tag counter=0, injection disarmed.
//  Push = in_valid && (level<DEPTH || pop). Pop = out_valid && out_ready.
//  Latency: sample pushed in cycle N appears on out_valid/out_data in cycle N+1 at the
//   earliest; no same-cycle bypass, even when empty.
//  Order strictly FIFO; each pushed sample gets the tag counter value, then the counter
//   increments; 2**SEQ_W-1 wraps to 0.
//  Full and in_valid without pop: sample dropped, tag counter NOT incremented,
//   overflow<=1 and holds until flush or reset.
//  Full with simultaneous pop and in_valid: push accepted, level stays DEPTH.
//  Empty: out_valid=0; out_data/out_seq hold last value (no X), out_ready ignored.
//  Stability: while out_valid && !out_ready, out_data/out_seq held unchanged.
//  Injection: inject_err=1 sets armed. When armed and out_valid, out_data bit 0 is
//   inverted (tag unchanged). Armed clears on that sample's pop. inject_err while
//   already armed: no effect (one corruption per arm).
//  flush=1: next cycle level=0, out_valid=0, tag counter=0, overflow=0, disarmed.
//   Flush wins over push, pop and inject_err in the same cycle.
//  level = pushes - pops, always 0..DEPTH; width $clog2(DEPTH)+1.
// STRUCTURE
//  trace_pkg: typedef trace_t (logic [LENGTH-1:0]), typedef seq_t, constant PTR_W.
//  Sub-module trace_fifo: DEPTH x (LENGTH+SEQ_W) register array, wrap-around rd/wr
//   pointers with extra MSB for full/empty, flush input; no reset on data storage
//   other than the output register.
//  Top: tag counter, overflow sticky, injection arm flop, bit-0 XOR on output.
// TESTING
//  1 Reset then push 0xA5A5_0001 in cycle 0, out_ready=1 -> out_valid=1 cycle 1,
//    out_data=0xA5A5_0001, out_seq=0; out_valid=0 cycle 2.
//  2 out_ready=0, push 9 samples back-to-back -> level=8, 9th dropped, overflow=1,
//    tags 0..7; drain -> 8 samples in order, overflow stays 1 until flush.
//  3 Full, cycle with in_valid=1 and out_ready=1 -> level stays 8, new sample gets
//    tag 8, overflow unchanged.
//  4 SEQ_W=4, push 20 samples with out_ready=1 -> tags 0..15,0..3 in order, no drop.
//  5 inject_err pulse, push 0x0000_0010 and 0x0000_0020 -> sent as 0x0000_0011 then
//    0x0000_0020; hold out_ready=0 three cycles first -> corrupted value stable.
//  6 Half-full plus pending inject, assert flush with in_valid=1 -> next cycle
//    level=0, out_valid=0, overflow=0; next push tagged 0, not corrupted;
//    rst_l low mid-stream -> outputs zero immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and default sizing for the trace replay transmitter
package trace_pkg;

  localparam int LENGTH_DEF = 32;
  localparam int DEPTH_DEF  = 8;
  localparam int SEQ_W_DEF  = 8;

  // Buffer index width for the default depth; the pointers carry one extra wrap bit.
  localparam int PTR_W = $clog2(DEPTH_DEF);

  typedef logic [LENGTH_DEF-1:0] trace_t;
  typedef logic [SEQ_W_DEF-1:0]  seq_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - tagged sample buffer with registered head and synchronous flush
module trace_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == LVL_FULL);
  assign rd_valid = (wr_ptr_q != rd_ptr_q);
  assign rd_data  = head_q;

  // Pointer advance and next-head selection; the head register is preloaded with the
  // entry that will be at the front next cycle, taking the incoming word when it lands there.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_ptr_d != rd_ptr_d) begin
        if (push && (rd_ptr_d == wr_ptr_q)) head_d = wr_data;
        else                                head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Pointers and head register; the head holds its last value while empty.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/trace_replay_tx.sv
// rtl/trace_replay_tx.sv - buffered, tagged trace sample transmitter with drop flag and error injection
module trace_replay_tx
  import trace_pkg::*;
#(
  parameter int LENGTH = LENGTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int SEQ_W  = SEQ_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   in_valid,
  input  logic [LENGTH-1:0]      in_data,
  input  logic                   flush,
  input  logic                   inject_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LENGTH-1:0]      out_data,
  output logic [SEQ_W-1:0]       out_seq,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  logic                    push, pop, full, fifo_valid;
  logic [SEQ_W+LENGTH-1:0] head;
  logic [SEQ_W-1:0]        tag_q, tag_d;
  logic                    overflow_q, overflow_d;
  logic                    armed_q, armed_d;

  // A full buffer still accepts a sample when the head leaves in the same cycle.
  assign pop  = fifo_valid && out_ready;
  assign push = in_valid && (!full || pop);

  trace_fifo #(
    .WIDTH (SEQ_W + LENGTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_l    (rst_l),
    .flush    (flush),
    .push     (push),
    .wr_data  ({tag_q, in_data}),
    .pop      (pop),
    .rd_data  (head),
    .rd_valid (fifo_valid),
    .full     (full),
    .level    (level)
  );

  assign out_valid = fifo_valid;
  assign out_seq   = head[LENGTH +: SEQ_W];
  assign out_data  = head[LENGTH-1:0] ^ {{(LENGTH-1){1'b0}}, armed_q & fifo_valid};
  assign overflow  = overflow_q;

  // Tag counter, sticky drop flag and one-shot corruption arm; flush overrides everything.
  always_comb begin
    tag_d      = tag_q;
    overflow_d = overflow_q;
    armed_d    = armed_q;
    if (flush) begin
      tag_d      = '0;
      overflow_d = 1'b0;
      armed_d    = 1'b0;
    end else begin
      if (push) tag_d = tag_q + SEQ_W'(1);
      if (in_valid && !push) overflow_d = 1'b1;
      if (armed_q && pop)  armed_d = 1'b0;
      else if (inject_err) armed_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tag_q      <= '0;
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      overflow_q <= overflow_d;
      armed_q    <= armed_d;
    end
  end

endmodule

// File: tb/tb_trace_replay_tx.sv
// tb/tb_trace_replay_tx.sv - scoreboard bench for trace_replay_tx
module tb_trace_replay_tx;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        in_valid, flush, inject_err, out_ready;
  logic [31:0] in_data;
  logic        out_valid, overflow;
  logic [31:0] out_data;
  logic [7:0]  out_seq;
  logic [3:0]  level;

  logic        in4_valid, out4_ready, flush4, inject4;
  logic [31:0] in4_data;
  logic        out4_valid, ov4;
  logic [31:0] out4_data;
  logic [3:0]  out4_seq;
  logic [3:0]  lvl4;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];
  logic [35:0] exp4_q[$];

  always #5 clk = ~clk;

  trace_replay_tx #(.LENGTH(32), .DEPTH(8), .SEQ_W(8)) u_dut (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .inject_err(inject_err), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_seq(out_seq),
    .overflow(overflow), .level(level)
  );

  trace_replay_tx #(.LENGTH(32), .DEPTH(8), .SEQ_W(4)) u_dut4 (
    .clk(clk), .rst_l(rst_l), .in_valid(in4_valid), .in_data(in4_data),
    .flush(flush4), .inject_err(inject4), .out_valid(out4_valid),
    .out_ready(out4_ready), .out_data(out4_data), .out_seq(out4_seq),
    .overflow(ov4), .level(lvl4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head sample is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_l && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", {out_seq, out_data});
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("sb_data", out_data, e[31:0]);
        chk("sb_seq", out_seq, e[39:32]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_l && out4_valid && out4_ready) begin
      if (exp4_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb4_unexpected actual=%0h required=none", {out4_seq, out4_data});
      end else begin
        logic [35:0] e;
        e = exp4_q.pop_front();
        chk("sb4_data", out4_data, e[31:0]);
        chk("sb4_seq", out4_seq, e[35:32]);
      end
    end
  end

  initial begin
    rst_l = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; inject_err = 1'b0;
    out_ready = 1'b0;
    in4_valid = 1'b0; in4_data = '0; out4_ready = 1'b1; flush4 = 1'b0; inject4 = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_seq", out_seq, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", level, 0);
    rst_l = 1'b1;

    // single sample, one-cycle latency, no bypass
    step();
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    exp_q.push_back({8'd0, 32'hA5A5_0001});
    @(negedge clk) chk("t1_no_bypass", out_valid, 0);
    step();
    in_valid = 1'b0;
    @(negedge clk) chk("t1_valid_c1", out_valid, 1);
    step();
    @(negedge clk) chk("t1_valid_c2", out_valid, 0);

    step(); flush = 1'b1;
    step(); flush = 1'b0; exp_q.delete();

    // fill past capacity with the checker stalled
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      in_valid = 1'b1; in_data = 32'h200 + i;
      if (i < 8) exp_q.push_back({i[7:0], 32'h200 + i});
    end
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("t2_level_full", level, 8);
    chk("t2_overflow", overflow, 1);
    chk("t2_head_data", out_data, 32'h200);
    chk("t2_head_seq", out_seq, 0);

    // full with simultaneous pop and push
    step();
    in_valid = 1'b1; in_data = 32'h300; out_ready = 1'b1;
    exp_q.push_back({8'd8, 32'h300});
    step(); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t3_level_stays", level, 8);
    chk("t3_overflow_held", overflow, 1);

    out_ready = 1'b1;
    repeat (10) step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_drained_level", level, 0);
    chk("t3_overflow_sticky", overflow, 1);
    chk("t3_sb_empty", exp_q.size(), 0);

    step(); flush = 1'b1;
    step(); flush = 1'b0; exp_q.delete();
    @(negedge clk);
    chk("flush_overflow", overflow, 0);
    chk("flush_level", level, 0);

    // tag wrap on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      step();
      in4_valid = 1'b1; in4_data = 32'h1000 + i;
      exp4_q.push_back({4'(i % 16), 32'h1000 + i});
    end
    step(); in4_valid = 1'b0;
    repeat (3) step();
    chk("t4_sb_empty", exp4_q.size(), 0);
    chk("t4_no_overflow", ov4, 0);

    // injected corruption, held stable under backpressure
    out_ready = 1'b0;
    step(); inject_err = 1'b1;
    step(); inject_err = 1'b0; in_valid = 1'b1; in_data = 32'h10;
    exp_q.push_back({8'd0, 32'h11});
    step(); in_data = 32'h20;
    exp_q.push_back({8'd1, 32'h20});
    step(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_data", out_data, 32'h11);
      chk("t5_stall_seq", out_seq, 0);
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    chk("t5_sb_empty", exp_q.size(), 0);

    // flush beats push and a pending injection
    for (int i = 0; i < 4; i++) begin
      step();
      in_valid = 1'b1; in_data = 32'h600 + i;
    end
    step(); in_valid = 1'b0; inject_err = 1'b1;
    step(); inject_err = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
    step(); inject_err = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t6_level", level, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_overflow", overflow, 0);
    step();
    in_valid = 1'b1; in_data = 32'h40; out_ready = 1'b1;
    exp_q.push_back({8'd0, 32'h40});
    step(); in_valid = 1'b0;
    repeat (2) step();
    chk("t6_sb_empty", exp_q.size(), 0);

    // asynchronous reset while a sample is presented
    out_ready = 1'b0;
    step(); in_valid = 1'b1; in_data = 32'h77;
    step(); in_valid = 1'b0;
    step();
    chk("t6_pre_rst_valid", out_valid, 1);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_seq", out_seq, 0);
    chk("arst_level", level, 0);
    step(); rst_l = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
